// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared write-back constants, mux select codes and pointer helper
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREQ   = 3;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_MUL  = 2'b10;
  localparam logic [1:0] SEL_IDLE = 2'b11;

  // Rotating pointer moves just past the winner; index 2 wraps to 0.
  function automatic logic [1:0] next_ptr(input logic [1:0] k);
    return (k == 2'd2) ? 2'd0 : k + 2'd1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - requester/hold inputs and write-back command bundle
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREQ   = 3
) ();

  logic [NREQ-1:0]   req;
  logic [ADDR_W-1:0] rd0;
  logic [ADDR_W-1:0] rd1;
  logic [ADDR_W-1:0] rd2;
  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic              hold;
  logic [NREQ-1:0]   gnt;
  logic [1:0]        wb_sel;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output req, rd0, rd1, rd2, d0, d1, d2, hold,
    input  gnt, wb_sel, wb_we, wb_addr, wb_data
  );

  modport slave (
    input  req, rd0, rd1, rd2, d0, d1, d2, hold,
    output gnt, wb_sel, wb_we, wb_addr, wb_data
  );

endinterface

// File: rtl/mux3to1.sv
// rtl/mux3to1.sv - three-input select mux shared with the write-back datapath
module mux3to1 import wb_pkg::*; #(
  parameter int W = 32
) (
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] a2,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  always_comb begin
    case (sel)
      SEL_ALU:  y = a0;
      SEL_LOAD: y = a1;
      SEL_MUL:  y = a2;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/wb_port_arbiter_rr_pick3.sv
// rtl/wb_port_arbiter_rr_pick3.sv - combinational rotating-priority picker for three requesters
module rr_pick3 import wb_pkg::*; (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic       hold,
  output logic [2:0] gnt,
  output logic [1:0] idx,
  output logic       valid
);

  logic [1:0] o0, o1, o2;

  always_comb begin
    case (ptr)
      2'd0:    begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
      2'd1:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      default: begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
    endcase

    valid = 1'b0;
    idx   = SEL_IDLE;
    if (!hold) begin
      if (req[o0]) begin
        valid = 1'b1;
        idx   = o0;
      end else if (req[o1]) begin
        valid = 1'b1;
        idx   = o1;
      end else if (req[o2]) begin
        valid = 1'b1;
        idx   = o2;
      end
    end

    gnt = valid ? (3'b001 << idx) : 3'b000;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin owner of the register-file write-back port
// Optional contention counter output conflict_cnt enabled by WB_ARB_PERF_EN.
module wb_port_arbiter import wb_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREQ   = 3
) (
  input  logic                clk,
  input  logic                reset,
`ifdef WB_ARB_PERF_EN
  output logic [31:0]         conflict_cnt,
`endif
  wb_port_arbiter_if.slave    bus
);

  logic [1:0]        ptr;
  logic [1:0]        idx;
  logic              valid;
  logic [NREQ-1:0]   gnt;
  logic [DATA_W-1:0] mux_data;
  logic [ADDR_W-1:0] mux_addr;

  // Reset masks the grant so nothing is consumed while the port restarts.
  rr_pick3 u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .hold  (bus.hold | reset),
    .gnt   (gnt),
    .idx   (idx),
    .valid (valid)
  );

  assign bus.gnt = gnt;

  mux3to1 #(.W(DATA_W)) u_data_mux (
    .a0  (bus.d0),
    .a1  (bus.d1),
    .a2  (bus.d2),
    .sel (idx),
    .y   (mux_data)
  );

  mux3to1 #(.W(ADDR_W)) u_addr_mux (
    .a0  (bus.rd0),
    .a1  (bus.rd1),
    .a2  (bus.rd2),
    .sel (idx),
    .y   (mux_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= 2'd0;
      bus.wb_we   <= 1'b0;
      bus.wb_sel  <= SEL_IDLE;
      bus.wb_addr <= '0;
      bus.wb_data <= '0;
    end else if (valid) begin
      ptr         <= next_ptr(idx);
      bus.wb_sel  <= idx;
      // Writes to x0 are consumed but never reach the register file.
      bus.wb_we   <= (mux_addr != '0);
      bus.wb_addr <= mux_addr;
      bus.wb_data <= mux_data;
    end else begin
      bus.wb_we   <= 1'b0;
      bus.wb_sel  <= SEL_IDLE;
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if ((|(bus.req & ~gnt)) && (cnt != 32'hFFFF_FFFF)) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign conflict_cnt = cnt;
`endif

endmodule
